// File: rtl/output_checker_pkg.sv
// output_checker_pkg: shared constants for the output checker block.
// FSM state encoding, counter saturation helper and channel-index width.
package output_checker_pkg;

    typedef logic [1:0] oc_state_t;

    localparam oc_state_t ST_IDLE   = 2'd0;
    localparam oc_state_t ST_WARM   = 2'd1;
    localparam oc_state_t ST_CHECK  = 2'd2;
    localparam oc_state_t ST_FAILED = 2'd3;

    // Width of the first-error channel index (supports up to 8 channels).
    localparam int CH_W = 3;

    // All-ones value of a w-bit counter: the saturation ceiling.
    function automatic logic [63:0] sat_max(input int unsigned w);
        logic [63:0] one_v;
        one_v = 64'd1;
        return (one_v << w) - 64'd1;
    endfunction

endpackage

// File: rtl/ref_delay_line.sv
// ref_delay_line: DEPTH-stage shift register that advances only when en_i
// is high. DEPTH=0 degenerates to a plain wire.
module ref_delay_line #(
    parameter int W     = 5,
    parameter int DEPTH = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_s;
            assign unused_s = ^{clk_i, rst_ni, en_i};
            assign q_o      = d_i;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [DEPTH];

            // Shift the reference one stage per enabled cycle
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (en_i) begin
                    pipe_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign q_o = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/output_checker.sv
// output_checker: clocked comparison of NUM_DUT implementation channels
// against a latency-aligned golden reference, with sticky flags, saturating
// counters and a first-error record.
// Optional macro OUTPUT_CHECKER_LOG_EN adds a simulation-only mismatch log.
module output_checker
    import output_checker_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NUM_DUT     = 4,
    parameter int CNT_W       = 16,
    parameter int REF_LAT     = 0,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       ENB,
    input  logic                       CLR,
    input  logic [WIDTH-1:0]           Q_REF,
    input  logic                       S_OUT_REF,
    input  logic [NUM_DUT*WIDTH-1:0]   Q_DUT,
    input  logic [NUM_DUT-1:0]         S_OUT_DUT,
    output logic [NUM_DUT-1:0]         ERR_FLAG,
    output logic [NUM_DUT*CNT_W-1:0]   ERR_CNT,
    output logic [CNT_W-1:0]           SAMPLE_CNT,
    output logic                       FIRST_ERR_VALID,
    output logic [CH_W-1:0]            FIRST_ERR_CH,
    output logic [CNT_W-1:0]           FIRST_ERR_CYC,
    output logic                       BUSY,
    output logic                       HALTED
);

    localparam int               RW      = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LAT_V   = 4'(REF_LAT);

    logic [RW-1:0]              ref_in_s;
    logic [RW-1:0]              ref_al_s;
    logic [NUM_DUT-1:0]         mism_s;
    logic [CH_W-1:0]            low_ch_s;
    logic                       compare_s;
    logic                       fail_s;

    oc_state_t                  state_q, state_d;
    logic [3:0]                 warm_q, warm_d;
    logic [CNT_W-1:0]           sample_q, sample_d;
    logic [NUM_DUT*CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [NUM_DUT-1:0]         err_flag_q, err_flag_d;
    logic                       fev_q, fev_d;
    logic [CH_W-1:0]            fch_q, fch_d;
    logic [CNT_W-1:0]           fcy_q, fcy_d;

    assign ref_in_s = {S_OUT_REF, Q_REF};

    ref_delay_line #(
        .W     (RW),
        .DEPTH (REF_LAT)
    ) u_ref_dly (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .en_i   (ENB),
        .d_i    (ref_in_s),
        .q_o    (ref_al_s)
    );

    // Per-channel inequality against the aligned reference, plus lowest failing index
    always_comb begin
        mism_s   = '0;
        low_ch_s = '0;
        for (int i = 0; i < NUM_DUT; i++) begin
            mism_s[i] = (Q_DUT[i*WIDTH +: WIDTH] != ref_al_s[WIDTH-1:0]) ||
                        (S_OUT_DUT[i] != ref_al_s[WIDTH]);
        end
        for (int i = NUM_DUT - 1; i >= 0; i--) begin
            if (mism_s[i]) begin
                low_ch_s = 3'(i);
            end else begin
                low_ch_s = low_ch_s;
            end
        end
    end

    // A cycle is compared once the aligned reference holds REF_LAT enabled
    // loads; with REF_LAT=0 the very first enabled sample in IDLE already counts.
    assign compare_s = ENB && !CLR &&
                       ((state_q == ST_CHECK) || ((state_q == ST_IDLE) && (LAT_V == 4'd0)));
    assign fail_s    = compare_s && (STOP_ON_ERR != 0) && (|mism_s);

    // FSM next state and warm-up load counter
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (CLR) begin
            state_d = ST_IDLE;
            warm_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ENB) begin
                        state_d = ST_IDLE;
                    end else if (fail_s) begin
                        state_d = ST_FAILED;
                    end else if (LAT_V <= 4'd1) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_WARM;
                        warm_d  = 4'd1;
                    end
                end
                ST_WARM: begin
                    if (!ENB) begin
                        state_d = ST_WARM;
                    end else if ((warm_q + 4'd1) >= LAT_V) begin
                        state_d = ST_CHECK;
                        warm_d  = 4'd0;
                    end else begin
                        warm_d  = warm_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (fail_s) begin
                        state_d = ST_FAILED;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_IDLE;
                    warm_d  = 4'd0;
                end
            endcase
        end
    end

    // Statistics update: clear, saturating counts, sticky flags, first-error capture
    always_comb begin
        sample_d   = sample_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        fev_d      = fev_q;
        fch_d      = fch_q;
        fcy_d      = fcy_q;
        if (CLR) begin
            sample_d   = '0;
            err_cnt_d  = '0;
            err_flag_d = '0;
            fev_d      = 1'b0;
            fch_d      = '0;
            fcy_d      = '0;
        end else if (compare_s) begin
            sample_d = (sample_q == CNT_MAX) ? sample_q : (sample_q + CNT_ONE);
            for (int i = 0; i < NUM_DUT; i++) begin
                err_cnt_d[i*CNT_W +: CNT_W] =
                    (mism_s[i] && (err_cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) ?
                    (err_cnt_q[i*CNT_W +: CNT_W] + CNT_ONE) : err_cnt_q[i*CNT_W +: CNT_W];
                err_flag_d[i] = err_flag_q[i] | mism_s[i];
            end
            if ((|mism_s) && !fev_q) begin
                fev_d = 1'b1;
                fch_d = low_ch_s;
                fcy_d = sample_q;
            end else begin
                fev_d = fev_q;
            end
        end else begin
            sample_d = sample_q;
        end
    end

    // State and statistics registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            warm_q     <= 4'd0;
            sample_q   <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= '0;
            fev_q      <= 1'b0;
            fch_q      <= '0;
            fcy_q      <= '0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            sample_q   <= sample_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
            fev_q      <= fev_d;
            fch_q      <= fch_d;
            fcy_q      <= fcy_d;
        end
    end

    assign ERR_FLAG        = err_flag_q;
    assign ERR_CNT         = err_cnt_q;
    assign SAMPLE_CNT      = sample_q;
    assign FIRST_ERR_VALID = fev_q;
    assign FIRST_ERR_CH    = fch_q;
    assign FIRST_ERR_CYC   = fcy_q;
    assign BUSY            = (state_q == ST_CHECK);
    assign HALTED          = (state_q == ST_FAILED);

`ifdef OUTPUT_CHECKER_LOG_EN
    // Simulation-only trace of every counted mismatch and of the halt event
    always @(posedge CLK) begin
        if (RESET_N && compare_s) begin
            for (int i = 0; i < NUM_DUT; i++) begin
                if (mism_s[i]) begin
                    $display("##########################################");
                    $display("t=%0t ch=%0d dut_q=%h ref_q=%h dut_s=%b ref_s=%b",
                             $time, i, Q_DUT[i*WIDTH +: WIDTH], ref_al_s[WIDTH-1:0],
                             S_OUT_DUT[i], ref_al_s[WIDTH]);
                    $display("##########################################");
                end
            end
        end
        if (RESET_N && (state_d == ST_FAILED) && (state_q != ST_FAILED)) begin
            $display("t=%0t checker halted", $time);
        end
    end
`endif

endmodule

// File: tb/tb_output_checker.sv
// tb_output_checker: directed-vector bench for output_checker. Four instances
// cover the default build, REF_LAT=2, STOP_ON_ERR=1 and CNT_W=4.
module tb_output_checker;

    logic        clk;
    logic        rst_n;
    logic        enb;
    logic        clr;
    logic [3:0]  q_ref;
    logic        s_ref;
    logic [15:0] q_dut;
    logic [3:0]  s_dut;
    logic [15:0] q_dut1;
    logic [3:0]  s_dut1;

    logic [3:0]  ef0, ef1, ef2, ef3;
    logic [63:0] ec0, ec1, ec2;
    logic [15:0] ec3;
    logic [15:0] sc0, sc1, sc2;
    logic [3:0]  sc3;
    logic        fv0, fv1, fv2, fv3;
    logic [2:0]  fch0, fch1, fch2, fch3;
    logic [15:0] fcy0, fcy1, fcy2;
    logic [3:0]  fcy3;
    logic        busy0, busy1, busy2, busy3;
    logic        halt0, halt1, halt2, halt3;

    int n_checks;
    int n_errors;

    output_checker u0 (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .CLR(clr), .Q_REF(q_ref), .S_OUT_REF(s_ref),
        .Q_DUT(q_dut), .S_OUT_DUT(s_dut), .ERR_FLAG(ef0), .ERR_CNT(ec0), .SAMPLE_CNT(sc0),
        .FIRST_ERR_VALID(fv0), .FIRST_ERR_CH(fch0), .FIRST_ERR_CYC(fcy0), .BUSY(busy0), .HALTED(halt0)
    );

    output_checker #(.REF_LAT(2)) u1 (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .CLR(clr), .Q_REF(q_ref), .S_OUT_REF(s_ref),
        .Q_DUT(q_dut1), .S_OUT_DUT(s_dut1), .ERR_FLAG(ef1), .ERR_CNT(ec1), .SAMPLE_CNT(sc1),
        .FIRST_ERR_VALID(fv1), .FIRST_ERR_CH(fch1), .FIRST_ERR_CYC(fcy1), .BUSY(busy1), .HALTED(halt1)
    );

    output_checker #(.STOP_ON_ERR(1)) u2 (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .CLR(clr), .Q_REF(q_ref), .S_OUT_REF(s_ref),
        .Q_DUT(q_dut), .S_OUT_DUT(s_dut), .ERR_FLAG(ef2), .ERR_CNT(ec2), .SAMPLE_CNT(sc2),
        .FIRST_ERR_VALID(fv2), .FIRST_ERR_CH(fch2), .FIRST_ERR_CYC(fcy2), .BUSY(busy2), .HALTED(halt2)
    );

    output_checker #(.CNT_W(4)) u3 (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .CLR(clr), .Q_REF(q_ref), .S_OUT_REF(s_ref),
        .Q_DUT(q_dut), .S_OUT_DUT(s_dut), .ERR_FLAG(ef3), .ERR_CNT(ec3), .SAMPLE_CNT(sc3),
        .FIRST_ERR_VALID(fv3), .FIRST_ERR_CH(fch3), .FIRST_ERR_CYC(fcy3), .BUSY(busy3), .HALTED(halt3)
    );

    // 100 MHz sampling clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and wait until just after the active edge
    task automatic step(input logic e, input logic c, input logic [3:0] qr, input logic sr,
                        input logic [15:0] qd, input logic [3:0] sd);
        enb   = e;
        clr   = c;
        q_ref = qr;
        s_ref = sr;
        q_dut = qd;
        s_dut = sd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] qr;
        logic       sr;
        logic [3:0] rh1, rh2;
        logic       sh1, sh2;

        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        enb    = 1'b0;
        clr    = 1'b0;
        q_ref  = 4'h0;
        s_ref  = 1'b0;
        q_dut  = 16'h0000;
        s_dut  = 4'h0;
        q_dut1 = 16'h0000;
        s_dut1 = 4'h0;
        rh1 = 4'h0; rh2 = 4'h0; sh1 = 1'b0; sh2 = 1'b0;

        // Reset state
        #3;
        chk("rst_flag", 64'(ef0), 64'h0);
        chk("rst_cnt", ec0, 64'h0);
        chk("rst_sample", 64'(sc0), 64'h0);
        chk("rst_busy", 64'(busy0), 64'h0);
        chk("rst_halt", 64'(halt2), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All channels equal for 20 enabled cycles
        for (int k = 0; k < 20; k++) begin
            qr = 4'(k);
            sr = 1'(k);
            step(1'b1, 1'b0, qr, sr, {4{qr}}, {4{sr}});
        end
        chk("eq_flag", 64'(ef0), 64'h0);
        chk("eq_sample", 64'(sc0), 64'd20);
        chk("eq_fev", 64'(fv0), 64'h0);
        chk("eq_busy", 64'(busy0), 64'h1);
        chk("sat_sample_w4", 64'(sc3), 64'd15);

        // Clear, then channel 2 Q mismatch on samples 7 and 9
        step(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 4'h0);
        chk("clr_sample", 64'(sc0), 64'h0);
        chk("clr_busy", 64'(busy0), 64'h0);
        for (int s = 0; s < 12; s++) begin
            if ((s == 7) || (s == 9)) begin
                step(1'b1, 1'b0, 4'h4, 1'b1, 16'h4544, 4'hF);
            end else begin
                step(1'b1, 1'b0, 4'h4, 1'b1, 16'h4444, 4'hF);
            end
            if (s == 6) chk("ch2_pre_flag", 64'(ef0), 64'h0);
            if (s == 7) begin
                chk("ch2_lat_flag", 64'(ef0), 64'h4);
                chk("ch2_lat_cnt", 64'(ec0[32 +: 16]), 64'd1);
            end
        end
        chk("ch2_flag", 64'(ef0), 64'h4);
        chk("ch2_cnt", 64'(ec0[32 +: 16]), 64'd2);
        chk("ch2_cnt0", 64'(ec0[0 +: 16]), 64'd0);
        chk("ch2_fch", 64'(fch0), 64'd2);
        chk("ch2_fcy", 64'(fcy0), 64'd7);
        chk("ch2_sample", 64'(sc0), 64'd12);

        // Channels 1 and 3 fail S_OUT together
        step(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 4'h0);
        step(1'b1, 1'b0, 4'h3, 1'b0, 16'h3333, 4'h0);
        step(1'b1, 1'b0, 4'h3, 1'b0, 16'h3333, 4'hA);
        step(1'b1, 1'b0, 4'h3, 1'b0, 16'h3333, 4'h0);
        chk("s13_fch", 64'(fch0), 64'd1);
        chk("s13_flag", 64'(ef0), 64'hA);
        chk("s13_cnt1", 64'(ec0[16 +: 16]), 64'd1);
        chk("s13_cnt3", 64'(ec0[48 +: 16]), 64'd1);
        chk("s13_fcy", 64'(fcy0), 64'd1);

        // REF_LAT=2: DUTs follow the reference delayed by two enabled samples
        step(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 4'h0);
        for (int k = 0; k < 10; k++) begin
            qr = 4'(3 * k + 1);
            sr = 1'(k >> 1);
            if (k < 2) begin
                q_dut1 = 16'hFFFF;
                s_dut1 = 4'hF;
            end else begin
                q_dut1 = {4{rh2}};
                s_dut1 = {4{sh2}};
            end
            step(1'b1, 1'b0, qr, sr, {4{qr}}, {4{sr}});
            rh2 = rh1; rh1 = qr; sh2 = sh1; sh1 = sr;
            if (k == 0) chk("lat_warm_busy", 64'(busy1), 64'h0);
            if (k == 5) begin
                chk("lat_mid_sample", 64'(sc1), 64'd4);
                q_dut1 = 16'h0000;
                s_dut1 = 4'h0;
                step(1'b0, 1'b0, 4'hA, 1'b1, 16'hAAAA, 4'hF);
                step(1'b0, 1'b0, 4'h5, 1'b0, 16'h5555, 4'h0);
                chk("lat_hold_sample", 64'(sc1), 64'd4);
                chk("lat_hold_busy", 64'(busy1), 64'h1);
            end
        end
        chk("lat_flag", 64'(ef1), 64'h0);
        chk("lat_sample", 64'(sc1), 64'd8);
        chk("lat_fev", 64'(fv1), 64'h0);
        // Undelayed DUT value must now mismatch the aligned reference
        q_dut1 = 16'hFFFF;
        s_dut1 = 4'hF;
        step(1'b1, 1'b0, 4'hF, 1'b1, 16'hFFFF, 4'hF);
        chk("lat_neg_flag", 64'(ef1), 64'hF);
        chk("lat_neg_sample", 64'(sc1), 64'd9);
        chk("lat_neg_fcy", 64'(fcy1), 64'd8);

        // STOP_ON_ERR=1: mismatch on channel 0 from sample 3 onward
        step(1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 4'h0);
        for (int s = 0; s < 6; s++) begin
            qr = 4'(s);
            if (s >= 3) step(1'b1, 1'b0, qr, 1'b0, {qr, qr, qr, ~qr}, 4'h0);
            else        step(1'b1, 1'b0, qr, 1'b0, {4{qr}}, 4'h0);
            if (s == 2) chk("stop_busy", 64'(busy2), 64'h1);
            if (s == 3) begin
                chk("stop_halt", 64'(halt2), 64'h1);
                chk("stop_cnt", 64'(ec2[0 +: 16]), 64'd1);
                chk("stop_sample", 64'(sc2), 64'd4);
            end
        end
        chk("stop_frz_cnt", 64'(ec2[0 +: 16]), 64'd1);
        chk("stop_frz_sample", 64'(sc2), 64'd4);
        chk("stop_fcy", 64'(fcy2), 64'd3);
        chk("stop_busy_off", 64'(busy2), 64'h0);
        // CLR wins over ENB and a concurrent mismatch
        step(1'b1, 1'b1, 4'h0, 1'b0, 16'h1234, 4'hF);
        chk("stop_clr_halt", 64'(halt2), 64'h0);
        chk("stop_clr_busy", 64'(busy2), 64'h0);
        chk("stop_clr_sample", 64'(sc2), 64'h0);
        chk("stop_clr_cnt", ec2, 64'h0);
        chk("stop_clr_fev", 64'(fv2), 64'h0);

        // CNT_W=4: 20 consecutive mismatches on channel 0 saturate at 15
        for (int k = 0; k < 20; k++) begin
            qr = 4'(k);
            step(1'b1, 1'b0, qr, 1'b0, {qr, qr, qr, ~qr}, 4'h0);
            if (k == 13) chk("w4_cnt14", 64'(ec3[3:0]), 64'd14);
        end
        chk("w4_cnt_sat", 64'(ec3), 64'h000F);
        chk("w4_sample_sat", 64'(sc3), 64'd15);
        chk("w4_flag", 64'(ef3), 64'h1);
        chk("w4_fcy", 64'(fcy3), 64'd0);

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(ec3), 64'h0);
        chk("arst_flag", 64'(ef3), 64'h0);
        chk("arst_sample", 64'(sc3), 64'h0);
        chk("arst_fev", 64'(fv3), 64'h0);
        chk("arst_busy", 64'(busy0), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enb   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
